// File: rtl/stream_rx_buffer.sv
// stream_rx_buffer
// Receive-side elastic buffer behind the 3-stage data/valid delay pipeline.
// The upstream stream is valid-only and cannot be stalled, so the buffer absorbs
// bursts in a first-word-fall-through FIFO. It re-presents the words as a
// valid/ready stream. Words that arrive while the FIFO is full are dropped.
// Each drop sets the sticky overflow flag and increments a saturating counter.

module stream_rx_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_vld,

    output logic [DATA_W-1:0]        out_data,
    output logic                     out_vld,
    input  logic                     out_rdy,

    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,

    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt,
    input  logic                     clr_stat
);

    // Address bits index the storage. The extra pointer MSB is a wrap bit, so
    // that full and empty can be told apart when the address bits are equal.
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              ptr_msb_diff;
    logic              ptr_addr_eq;
    logic              empty_w;
    logic              full_w;
    logic              pop;
    logic              push;
    logic              drop;

    // Status derived purely from the registered pointers
    always_comb begin
        ptr_msb_diff = wr_ptr_q[PTR_W-1] ^ rd_ptr_q[PTR_W-1];
        ptr_addr_eq  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_w      = (wr_ptr_q == rd_ptr_q);
        full_w       = ptr_msb_diff && ptr_addr_eq;
    end

    // Transfer qualifiers: a pop in the same cycle frees a slot, so a full
    // FIFO still accepts a word. A pop needs a valid head, so an empty FIFO
    // never pops in the cycle of its first push.
    always_comb begin
        pop  = !empty_w && out_rdy;
        push = in_vld && (!full_w || pop);
        drop = in_vld && full_w && !pop;
    end

    // Next-state for the pointers and the loss statistics
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (clr_stat) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end

        // A drop in the same cycle as a clear is still recorded, so that no
        // loss can be hidden by a poorly timed clear.
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_stat) begin
                drop_cnt_d = CNT_ONE;
            end else if (drop_cnt_q != CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + CNT_ONE;
            end
        end
    end

    // Pointer and statistics registers; reset discards all buffered words
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage write. No reset is needed because an entry is only read after it
    // has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    // Head-of-FIFO presentation, forced to zero when empty
    always_comb begin
        out_data = '0;
        if (!empty_w) begin
            out_data = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    // The pointer difference gives the level directly, 0..DEPTH
    always_comb begin
        out_vld  = !empty_w;
        empty    = empty_w;
        full     = full_w;
        level    = wr_ptr_q - rd_ptr_q;
        overflow = overflow_q;
        drop_cnt = drop_cnt_q;
    end

endmodule

// File: tb/tb_stream_rx_buffer.sv
// tb_stream_rx_buffer
// Directed bench for stream_rx_buffer. Inputs are driven and outputs are
// sampled on the falling clock edge.

module tb_stream_rx_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;

    logic                    clk;
    logic                    reset_n;
    logic [DATA_W-1:0]       in_data;
    logic                    in_vld;
    logic [DATA_W-1:0]       out_data;
    logic                    out_vld;
    logic                    out_rdy;
    logic [$clog2(DEPTH):0]  level;
    logic                    full;
    logic                    empty;
    logic                    overflow;
    logic [CNT_W-1:0]        drop_cnt;
    logic                    clr_stat;

    int n_checks = 0;
    int n_pass   = 0;

    stream_rx_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .clr_stat (clr_stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One word presented for exactly one clock edge
    task automatic push_word(input logic [31:0] d);
        in_vld  = 1'b1;
        in_data = d;
        step();
        in_vld  = 1'b0;
        in_data = '0;
    endtask

    task automatic fill_a0();
        out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) push_word(32'hA0 + i);
    endtask

    int lvl_max;
    int rx_idx;
    logic [31:0] exp3 [8];

    initial begin
        reset_n  = 1'b0;
        in_data  = '0;
        in_vld   = 1'b0;
        out_rdy  = 1'b0;
        clr_stat = 1'b0;

        // Reset state
        #1;
        check("rst_out_vld",  32'(out_vld),  0);
        check("rst_out_data", out_data,      0);
        check("rst_empty",    32'(empty),    1);
        check("rst_full",     32'(full),     0);
        check("rst_level",    32'(level),    0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Pass-through, one-cycle latency
        out_rdy = 1'b1;
        lvl_max = 0;
        for (int i = 0; i < 4; i++) begin
            in_vld  = 1'b1;
            in_data = 32'h11 * (i + 1);
            step();
            check("pt_out_vld",  32'(out_vld), 1);
            check("pt_out_data", out_data,     32'h11 * (i + 1));
            if (int'(level) > lvl_max) lvl_max = int'(level);
        end
        in_vld  = 1'b0;
        in_data = '0;
        step();
        check("pt_level_max", 32'(lvl_max),  1);
        check("pt_empty",     32'(empty),    1);
        check("pt_out_vld_0", 32'(out_vld),  0);
        check("pt_drop_cnt",  32'(drop_cnt), 0);

        // Fill, stall and overflow
        fill_a0();
        check("fill_full",  32'(full),  1);
        check("fill_level", 32'(level), 8);
        check("fill_head",  out_data,   32'hA0);
        push_word(32'hFF);
        push_word(32'hFE);
        check("ovf_overflow", 32'(overflow), 1);
        check("ovf_drop_cnt", 32'(drop_cnt), 2);
        check("ovf_level",    32'(level),    8);
        check("ovf_head",     out_data,      32'hA0);
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_vld",  32'(out_vld), 1);
            check("drain_data", out_data,     32'hA0 + i);
            step();
        end
        check("drain_empty", 32'(empty), 1);

        // Full with concurrent pop
        fill_a0();
        in_vld  = 1'b1;
        in_data = 32'h55;
        out_rdy = 1'b1;
        step();
        in_vld  = 1'b0;
        in_data = '0;
        check("fp_level",    32'(level),    8);
        check("fp_drop_cnt", 32'(drop_cnt), 2);
        for (int i = 0; i < 7; i++) exp3[i] = 32'hA1 + i;
        exp3[7] = 32'h55;
        for (int i = 0; i < 8; i++) begin
            check("fp_data", out_data, exp3[i]);
            step();
        end
        check("fp_empty", 32'(empty), 1);

        // Wrap-around: push every other cycle while out_rdy toggles
        rx_idx  = 0;
        out_rdy = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    push_word(i);
                    step();
                end
            end
            begin
                for (int c = 0; c < 120 && rx_idx < 20; c++) begin
                    out_rdy = ~out_rdy;
                    if (out_vld && out_rdy) begin
                        check("wrap_data", out_data, rx_idx);
                        rx_idx++;
                    end
                    step();
                end
                out_rdy = 1'b0;
            end
        join
        check("wrap_count",    32'(rx_idx),   20);
        check("wrap_empty",    32'(empty),    1);
        check("wrap_drop_cnt", 32'(drop_cnt), 2);

        // Statistics clear racing a drop
        fill_a0();
        push_word(32'hEE);
        check("race_pre_cnt", 32'(drop_cnt), 3);
        check("race_pre_ovf", 32'(overflow), 1);
        in_vld   = 1'b1;
        in_data  = 32'hED;
        clr_stat = 1'b1;
        step();
        in_vld   = 1'b0;
        check("race_ovf", 32'(overflow), 1);
        check("race_cnt", 32'(drop_cnt), 1);
        step();
        clr_stat = 1'b0;
        check("clr_ovf",   32'(overflow), 0);
        check("clr_cnt",   32'(drop_cnt), 0);
        check("clr_level", 32'(level),    8);
        check("clr_head",  out_data,      32'hA0);

        // Reset mid-operation with level 5 and a non-zero drop count
        push_word(32'hDD);
        check("mid_drop_cnt", 32'(drop_cnt), 1);
        out_rdy = 1'b1;
        step();
        step();
        step();
        out_rdy = 1'b0;
        check("mid_level", 32'(level), 5);
        #1 reset_n = 1'b0;
        #1;
        check("arst_out_vld",  32'(out_vld),  0);
        check("arst_level",    32'(level),    0);
        check("arst_drop_cnt", 32'(drop_cnt), 0);
        check("arst_overflow", 32'(overflow), 0);
        check("arst_out_data", out_data,      0);
        #1 reset_n = 1'b1;
        step();
        push_word(32'h77);
        check("post_vld",   32'(out_vld), 1);
        check("post_data",  out_data,     32'h77);
        check("post_level", 32'(level),   1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
